// File: rtl/zrb_uart_tx_sched.sv
// zrb_uart_tx_sched: round-robin scheduler sharing one serial byte transmitter among NUM_REQ sources.
// Optional build macro ZRB_UART_SCHED_PRIO0_EN gives source 0 absolute priority over the round-robin sources.
module zrb_uart_tx_sched #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 1023,
   localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_ready,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int SW  = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [SW-1:0]  START_MAX = SW'(START_TIMEOUT);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [SW-1:0]          start_cnt_r;
   logic [GCW-1:0]         gap_cnt_r;
   logic [NUM_REQ-1:0]     cand_s;
   logic [GW-1:0]          sel_s;
   logic                   found_s;
   logic                   rr_s;
   logic [NUM_REQ-1:0]     ack_s;
   logic [DATA_WIDTH-1:0]  tx_data_s;
   logic [GW-1:0]          grant_id_s;
   logic                   tx_start_s;
   logic                   timeout_s;
   logic                   busy_s;

   // Arbiter: first candidate scanning upward from one past the last round-robin grant
   always_comb begin
      cand_s  = req;
      sel_s   = grant_id;
      found_s = 1'b0;
      rr_s    = 1'b1;
`ifdef ZRB_UART_SCHED_PRIO0_EN
      cand_s[0] = 1'b0;
`endif
      // Descending scan so the nearest candidate is the last one written
      for (int k = NUM_REQ; k >= 1; k--) begin
         found_s = found_s | cand_s[(int'(grant_id) + k) % NUM_REQ];
         sel_s   = cand_s[(int'(grant_id) + k) % NUM_REQ] ? GW'((int'(grant_id) + k) % NUM_REQ) : sel_s;
      end
`ifdef ZRB_UART_SCHED_PRIO0_EN
      rr_s    = ~req[0];
      found_s = found_s | req[0];
      sel_s   = req[0] ? {GW{1'b0}} : sel_s;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (found_s && tx_ready) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (tx_start && !tx_ready) begin
               state_s = WAIT_DONE;
            end else if (start_cnt_r == START_MAX) begin
               state_s = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               state_s = START;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               state_s = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               state_s = IDLE;
            end else begin
               state_s = GAP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      ack_s      = {NUM_REQ{1'b0}};
      tx_data_s  = tx_data;
      grant_id_s = grant_id;
      tx_start_s = 1'b0;
      timeout_s  = timeout_err;
      busy_s     = (state_s != IDLE);
      case (state_r)
         IDLE: begin
            if (state_s == START) begin
               ack_s[sel_s] = 1'b1;
               tx_data_s    = req_data[sel_s*DATA_WIDTH +: DATA_WIDTH];
               grant_id_s   = rr_s ? sel_s : grant_id;
            end else begin
               ack_s = {NUM_REQ{1'b0}};
            end
         end
         START: begin
            tx_start_s = (state_s == START);
            // Leaving START anywhere but WAIT_DONE means the transmitter never answered
            timeout_s  = timeout_err | ((state_s != START) && (state_s != WAIT_DONE));
         end
         default: tx_start_s = 1'b0;
      endcase
   end

   // Output and counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ack         <= {NUM_REQ{1'b0}};
         tx_start    <= 1'b0;
         tx_data     <= {DATA_WIDTH{1'b0}};
         grant_id    <= GW'(NUM_REQ - 1);
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         start_cnt_r <= {SW{1'b0}};
         gap_cnt_r   <= {GCW{1'b0}};
      end else begin
         ack         <= ack_s;
         tx_start    <= tx_start_s;
         tx_data     <= tx_data_s;
         grant_id    <= grant_id_s;
         busy        <= busy_s;
         timeout_err <= timeout_s;
         start_cnt_r <= ((state_r == START) && (state_s == START)) ? start_cnt_r + SW'(1) : {SW{1'b0}};
         gap_cnt_r   <= ((state_r == GAP) && (state_s == GAP)) ? gap_cnt_r + GCW'(1) : {GCW{1'b0}};
      end
   end

endmodule

// File: tb/tb_zrb_uart_tx_sched.sv
// Self-checking bench for zrb_uart_tx_sched: event-timing reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_zrb_uart_tx_sched;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int GAP = 16;
   localparam int TO  = 1023;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            tx_ready = 1'b1;
   logic [N-1:0]    ack;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout_err;

   zrb_uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transmitter stand-in: ready falls after TX_DROP cycles of tx_start, frame lasts FRAME cycles
   localparam int TX_DROP = 3;
   localparam int FRAME   = 20;
   bit tx_stuck = 1'b0;
   bit tx_hold_low = 1'b0;
   initial begin
      int scnt;
      int fcnt;
      scnt = 0;
      fcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (tx_hold_low) begin
            tx_ready = 1'b0;
         end else if (fcnt > 0) begin
            fcnt--;
            tx_ready = (fcnt == 0);
         end else if (tx_start && !tx_stuck) begin
            scnt++;
            if (scnt == TX_DROP) begin
               tx_ready = 1'b0;
               fcnt = FRAME;
               scnt = 0;
            end
         end else begin
            scnt = 0;
            tx_ready = 1'b1;
         end
      end
   end

   // Reference model: tracks grant edge, start window and earliest next-grant edge
   int n = 0;
   bit model_valid = 1'b0;
   bit in_frame = 1'b0;
   bit start_done = 1'b0;
   int g = 0;
   int free_edge = 0;
   int ptr = N - 1;
   logic [N-1:0]  m_ack = '0;
   logic          m_start = 1'b0;
   logic          m_busy = 1'b0;
   logic          m_terr = 1'b0;
   logic [DW-1:0] m_data = '0;

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int sel;
      n++;
      if (!reset_n) begin
         model_valid = 1'b1;
         in_frame = 1'b0;
         free_edge = n + 1;
         ptr = N - 1;
         m_ack = '0; m_start = 1'b0; m_busy = 1'b0; m_terr = 1'b0; m_data = '0;
      end else if (model_valid) begin
         m_ack = '0;
         if (!in_frame) begin
            if (n >= free_edge && (|req) && tx_ready) begin
`ifdef ZRB_UART_SCHED_PRIO0_EN
               if (req[0]) sel = 0;
               else begin sel = pick(req & 4'b1110, ptr); ptr = sel; end
`else
               sel = pick(req, ptr);
               ptr = sel;
`endif
               m_ack[sel] = 1'b1;
               m_data = req_data[sel*DW +: DW];
               in_frame = 1'b1;
               start_done = 1'b0;
               g = n;
            end
         end else if (!start_done) begin
            if (n == g + 1) m_start = 1'b1;
            else if (!tx_ready) begin m_start = 1'b0; start_done = 1'b1; end
            else if (n == g + 1 + TO) begin
               m_start = 1'b0; m_terr = 1'b1; in_frame = 1'b0; free_edge = n + GAP + 1;
            end
         end else if (tx_ready) begin
            in_frame = 1'b0;
            free_edge = n + GAP + 1;
         end
         m_busy = in_frame || (n < free_edge - 1);
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         chk("ack", 32'(ack), 32'(m_ack));
         chk("tx_start", 32'(tx_start), 32'(m_start));
         chk("tx_data", 32'(tx_data), 32'(m_data));
         chk("grant_id", 32'(grant_id), 32'(ptr));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ack(input string name, input int budget, output int idx, output int waited);
      idx = -1;
      waited = 0;
      while (idx < 0 && waited < budget) begin
         tick();
         waited++;
         for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      end
      if (idx < 0) begin
         checks++; failures++;
         $display("FAIL %s: no ack within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int w;
      w = 0;
      while (busy && w < budget) begin tick(); w++; end
      if (busy) begin
         checks++; failures++;
         $display("FAIL %s: busy still high after %0d cycles", name, budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, w, hi;
      int t1_exp[5];
      int t6_exp[4];
`ifdef ZRB_UART_SCHED_PRIO0_EN
      t1_exp = '{0, 0, 0, 0, 0};
      t6_exp = '{0, 0, 0, 0};
`else
      t1_exp = '{0, 1, 2, 3, 0};
      t6_exp = '{0, 3, 0, 3};
`endif
      // Reset
      reset_n = 1'b0;
      tick(); tick();
      chk("rst_grant_id", 32'(grant_id), 32'd3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      reset_n = 1'b1;

      // 1: all four requesting
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack("t1_ack", 200, idx, w);
         chk("t1_order", 32'(idx), 32'(t1_exp[k]));
         chk("t1_data", 32'(tx_data), 32'(8'hA0 + 8'(t1_exp[k])));
         if (k > 0) chk("t1_ack_spacing", 32'(w), 32'd41);
      end
      req = 4'b0000;
      wait_idle("t1_idle", 100);

      // 2: single source, latency
      req_data[2*DW +: DW] = 8'h5A;
      req = 4'b0100;
      tick();
      chk("t2_ack", 32'(ack), 32'h4);
      chk("t2_data", 32'(tx_data), 32'h5A);
      chk("t2_start_not_yet", 32'(tx_start), 32'd0);
      req = 4'b0000;
      tick();
      hi = 0;
      while (tx_start && hi < 50) begin hi++; tick(); end
      chk("t2_start_len", 32'(hi), 32'd3);
      wait_idle("t2_idle", 100);

      // 3: start timeout
      tx_stuck = 1'b1;
      req_data[1*DW +: DW] = 8'h3C;
      req = 4'b0010;
      wait_ack("t3_ack", 50, idx, w);
      req = 4'b0000;
      tick();
      hi = 0;
      while (tx_start && hi < 2000) begin hi++; tick(); end
      chk("t3_start_len", 32'(hi), 32'd1023);
      chk("t3_timeout_err", 32'(timeout_err), 32'd1);
      tx_stuck = 1'b0;
      req_data[3*DW +: DW] = 8'h77;
      req = 4'b1000;
      wait_ack("t3_recover", 100, idx, w);
      chk("t3_recover_id", 32'(idx), 32'd3);
      chk("t3_recover_data", 32'(tx_data), 32'h77);
      req = 4'b0000;
      wait_idle("t3_idle", 100);
      chk("t3_sticky", 32'(timeout_err), 32'd1);

      // 4: request while transmitter busy
      tx_hold_low = 1'b1;
      tick(); tick();
      req_data[1*DW +: DW] = 8'h11;
      req = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_no_ack", 32'(ack), 32'd0);
      end
      tx_hold_low = 1'b0;
      wait_ack("t4_ack", 20, idx, w);
      chk("t4_id", 32'(idx), 32'd1);
      chk("t4_data", 32'(tx_data), 32'h11);
      req = 4'b0000;
      wait_idle("t4_idle", 100);

      // 5: reset during WAIT_DONE
      req_data[2*DW +: DW] = 8'h22;
      req = 4'b0100;
      wait_ack("t5_ack", 50, idx, w);
      req = 4'b0000;
      hi = 0;
      while (!(tx_ready == 1'b0 && !tx_start) && hi < 50) begin hi++; tick(); end
      tick();
      reset_n = 1'b0;
      req_data[1*DW +: DW] = 8'h21;
      req = 4'b0110;
      tick();
      chk("t5_rst_ack", 32'(ack), 32'd0);
      chk("t5_rst_start", 32'(tx_start), 32'd0);
      chk("t5_rst_data", 32'(tx_data), 32'd0);
      chk("t5_rst_gid", 32'(grant_id), 32'd3);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_terr", 32'(timeout_err), 32'd0);
      reset_n = 1'b1;
      wait_ack("t5_regrant", 100, idx, w);
      chk("t5_regrant_id", 32'(idx), 32'd1);
      chk("t5_regrant_data", 32'(tx_data), 32'h21);
      req = 4'b0000;
      wait_idle("t5_idle", 100);

      // 6: sources 0 and 3 continuously requesting
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req_data[0*DW +: DW] = 8'hB0;
      req_data[3*DW +: DW] = 8'hB3;
      req = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         wait_ack("t6_ack", 200, idx, w);
         chk("t6_order", 32'(idx), 32'(t6_exp[k]));
      end
      req = 4'b0000;
      wait_idle("t6_idle", 100);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
